// File: rtl/program_feeder.sv
// rtl/program_feeder.sv - program store that streams opcode/immediate byte pairs into the CPU core
// Fetches are triggered by send_ins rising edges; the PC is sampled one cycle after each request.
module program_feeder #(
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int INS_HOLD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              start,
  input  logic [7:0]        cpu_status,
  output logic [7:0]        cpu_bus,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count
);

  localparam int HW = (INS_HOLD > 1) ? $clog2(INS_HOLD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PC,
    DRIVE_OP,
    DRIVE_IMM,
    HALT
  } state_t;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [HW-1:0]     hold_cnt;
  logic              send_prev;

  logic              send_ins;
  logic              invalid_ins;
  logic [ADDR_W-1:0] pc;
  logic              req;
  logic [15:0]       word_addr;
  logic [15:0]       word_pc;
  logic [15:0]       word_first;

  assign send_ins    = cpu_status[7];
  assign invalid_ins = cpu_status[6];
  assign pc          = cpu_status[ADDR_W-1:0];
  assign req         = send_ins & ~send_prev;
  assign word_addr   = mem[addr];
  assign word_pc     = mem[pc];
  assign word_first  = mem[0];

  // Program store is deliberately left out of reset so a restart replays the loaded program.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we && !start) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_bus   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 8'h00;
      hold_cnt  <= '0;
      send_prev <= 1'b0;
      addr      <= '0;
    end else begin
      send_prev <= send_ins;
      if (invalid_ins && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              state   <= HALT;
              cpu_bus <= 8'h00;
              done    <= 1'b1;
            end else begin
              state    <= DRIVE_OP;
              addr     <= '0;
              cpu_bus  <= word_first[15:8];
              busy     <= 1'b1;
              hold_cnt <= '0;
            end
          end
        end

        // Requests arriving here are swallowed: the opcode window always runs its full length.
        DRIVE_OP: begin
          if (hold_cnt == HW'(INS_HOLD - 1)) begin
            state   <= DRIVE_IMM;
            cpu_bus <= word_addr[7:0];
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        DRIVE_IMM: begin
          if (req) begin
            state <= WAIT_PC;
          end
        end

        // The core has updated its PC by now, so branches and wrap need no special casing.
        WAIT_PC: begin
          if (pc >= prog_len) begin
            state   <= HALT;
            cpu_bus <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state    <= DRIVE_OP;
            addr     <= pc;
            cpu_bus  <= word_pc[15:8];
            hold_cnt <= '0;
          end
        end

        HALT: begin
          cpu_bus <= 8'h00;
          done    <= 1'b1;
          busy    <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          cpu_bus <= 8'h00;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
